// File: rtl/dcache_ctrl_if.sv
// CPU load/store and data-memory signals for dcache_ctrl, grouped as one bundle.
// The cache connects through the slave modport; the pipeline/memory side uses master.
interface dcache_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write_en;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
        output rdata, stall, mem_addr, mem_wdata, mem_write_en, mem_funct3
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rdata,
        input  rdata, stall, mem_addr, mem_wdata, mem_write_en, mem_funct3
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache. Hits resolve combinationally;
// misses stall through optional dirty-line writeback and a word-by-word refill.
module dcache_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input logic         clk,
    input logic         rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int unsigned NWORDS = NUM_SETS * WORDS_PER_LINE;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t                state_q, next_state;
    logic [OFF_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SETS-1:0]   valid_q, dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_q [NWORDS];

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [OFF_W-1:0]       req_word;
    logic [1:0]             req_byte;
    logic                   hit, acc_ok;
    logic [4:0]             sh_amt;
    logic [DATA_WIDTH-1:0]  lane_mask, cur_word, shifted, merged, load_val;

    logic                   data_we, fill_done, set_dirty;
    logic [IDX_W+OFF_W-1:0] data_widx;
    logic [DATA_WIDTH-1:0]  data_wval;
    logic [DATA_WIDTH-1:0]  rdata_c, mem_wdata_c;
    logic [ADDR_WIDTH-1:0]  mem_addr_c;
    logic                   stall_c, mem_we_c;

    assign req_byte = bus.req_addr[1:0];
    assign req_word = bus.req_addr[OFF_W+1:2];
    assign req_idx  = bus.req_addr[OFF_W+2 +: IDX_W];
    assign req_tag  = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign hit      = bus.req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign cur_word = data_q[{req_idx, req_word}];

    // Loads allow signed/unsigned byte, half and word; stores only byte, half, word.
    always_comb begin
        acc_ok = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: acc_ok = 1'b1;
            3'b100, 3'b101:         acc_ok = !bus.req_write;
            default:                acc_ok = 1'b0;
        endcase
    end

    // Lane select ignores address bits below the access size, so nothing crosses a word.
    always_comb begin
        sh_amt    = 5'd0;
        lane_mask = '1;
        case (bus.req_funct3[1:0])
            2'b00: begin
                sh_amt    = {req_byte, 3'b000};
                lane_mask = DATA_WIDTH'(8'hFF);
            end
            2'b01: begin
                sh_amt    = {req_byte[1], 4'b0000};
                lane_mask = DATA_WIDTH'(16'hFFFF);
            end
            default: begin
                sh_amt    = 5'd0;
                lane_mask = '1;
            end
        endcase
        merged  = (cur_word & ~(lane_mask << sh_amt)) | ((bus.req_wdata & lane_mask) << sh_amt);
        shifted = cur_word >> sh_amt;
        case (bus.req_funct3)
            3'b000:  load_val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_val = cur_word;
        endcase
    end

    always_comb begin
        next_state  = state_q;
        cnt_d       = cnt_q;
        data_we     = 1'b0;
        data_widx   = {req_idx, req_word};
        data_wval   = merged;
        fill_done   = 1'b0;
        set_dirty   = 1'b0;
        rdata_c     = '0;
        stall_c     = 1'b0;
        mem_addr_c  = {bus.req_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        mem_wdata_c = '0;
        mem_we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && acc_ok) begin
                    if (hit) begin
                        if (bus.req_write) begin
                            data_we   = 1'b1;
                            set_dirty = 1'b1;
                        end else begin
                            rdata_c = load_val;
                        end
                    end else begin
                        stall_c    = 1'b1;
                        cnt_d      = '0;
                        next_state = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall_c     = 1'b1;
                mem_addr_c  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
                mem_wdata_c = data_q[{req_idx, cnt_q}];
                mem_we_c    = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    cnt_d      = '0;
                    next_state = REFILL;
                end
            end
            REFILL: begin
                stall_c    = 1'b1;
                mem_addr_c = {req_tag, req_idx, cnt_q, 2'b00};
                data_we    = 1'b1;
                data_widx  = {req_idx, cnt_q};
                data_wval  = bus.mem_rdata;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    cnt_d      = '0;
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Quiet the bus and suppress array writes while reset is asserted.
        if (!rst_n) begin
            rdata_c   = '0;
            stall_c   = 1'b0;
            mem_we_c  = 1'b0;
            data_we   = 1'b0;
            fill_done = 1'b0;
            set_dirty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= next_state;
            cnt_q   <= cnt_d;
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
            if (set_dirty) dirty_q[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (data_we) data_q[data_widx] <= data_wval;
        if (fill_done) tag_q[req_idx] <= req_tag;
    end

    assign bus.rdata        = rdata_c;
    assign bus.stall        = stall_c;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = mem_wdata_c;
    assign bus.mem_write_en = mem_we_c;
    assign bus.mem_funct3   = 3'b010;
endmodule
